// File: rtl/reg_bus_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_bus_sequencer_pkg
//  Description : Shared constants for the register-bus sequencer slice:
//                FSM state encodings, requester count and transfer-counter
//                width.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_bus_sequencer_pkg;

    // Sequencer FSM encodings
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_drive = 2'd1;
    localparam logic [1:0] c_st_write = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    // Number of requesters sharing the bus
    localparam int c_num_req = 2;

    // Width of the optional completed-transfer counter
    localparam int c_xfer_cnt_w = 16;

endpackage : reg_bus_sequencer_pkg
`default_nettype wire

// File: rtl/reg_bus_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_bus_sequencer_if
//  Description : Command handshake and register-bank control bundle of the
//                register-bus sequencer.
//                  i_w_valid/i_w_src/i_w_dst : per-requester commands
//                  o_w_ready                 : per-requester accept
//                  o_w_oe/o_w_we             : one-hot bank enables
//                  o_w_done/o_w_done_id/o_w_err : completion reporting
//                  o_w_xfer_count            : only with
//                                              REG_BUS_SEQ_XFER_COUNT_EN
//                Modport "master" is the requester/bank side, "slave" is the
//                sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface reg_bus_sequencer_if #(
    parameter int P_NUM_REGS  = 4,
    parameter int P_IDX_WIDTH = 2
);
    import reg_bus_sequencer_pkg::*;

    logic [c_num_req-1:0]             i_w_valid;
    logic [c_num_req*P_IDX_WIDTH-1:0] i_w_src;
    logic [c_num_req*P_IDX_WIDTH-1:0] i_w_dst;
    logic [c_num_req-1:0]             o_w_ready;
    logic [P_NUM_REGS-1:0]            o_w_oe;
    logic [P_NUM_REGS-1:0]            o_w_we;
    logic                             o_w_done;
    logic                             o_w_done_id;
    logic                             o_w_err;

`ifdef REG_BUS_SEQ_XFER_COUNT_EN
    logic [c_xfer_cnt_w-1:0]          o_w_xfer_count;

    modport master (
        output i_w_valid, i_w_src, i_w_dst,
        input  o_w_ready, o_w_oe, o_w_we, o_w_done, o_w_done_id, o_w_err,
        input  o_w_xfer_count
    );

    modport slave (
        input  i_w_valid, i_w_src, i_w_dst,
        output o_w_ready, o_w_oe, o_w_we, o_w_done, o_w_done_id, o_w_err,
        output o_w_xfer_count
    );
`else
    modport master (
        output i_w_valid, i_w_src, i_w_dst,
        input  o_w_ready, o_w_oe, o_w_we, o_w_done, o_w_done_id, o_w_err
    );

    modport slave (
        input  i_w_valid, i_w_src, i_w_dst,
        output o_w_ready, o_w_oe, o_w_we, o_w_done, o_w_done_id, o_w_err
    );
`endif

endinterface : reg_bus_sequencer_if
`default_nettype wire

// File: rtl/reg_bus_sequencer_rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-way combinational round-robin grant. The requester named
//                by the pointer wins if it is valid; otherwise the other one
//                wins if it is valid.
//                  i_valid[1:0] : request lines
//                  i_ptr        : priority pointer (0/1)
//                  o_grant[1:0] : one-hot grant, zero when nobody requests
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
    input  logic [1:0] i_valid,
    input  logic       i_ptr,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        if (i_valid[i_ptr]) begin
            o_grant[i_ptr] = 1'b1;
        end else if (i_valid[~i_ptr]) begin
            o_grant[~i_ptr] = 1'b1;
        end
    end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/reg_bus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : reg_bus_sequencer
//  Description : Shares a bank of oe/we-controlled registers on one data bus
//                between two requesters. Each accepted command moves the
//                source register onto the bus (DRIVE, one settle cycle), then
//                strobes the destination write enable (WRITE), then reports
//                completion (DONE). Commands naming a register index beyond
//                the bank are accepted and answered with a one-cycle error.
//  Ports       : i_w_clk   - clock, rising edge
//                i_w_reset - asynchronous active-high reset
//                bus       - reg_bus_sequencer_if.slave (commands, ready,
//                            oe/we enables, done/done_id/err, optional count)
//  Options     : REG_BUS_SEQ_XFER_COUNT_EN adds a 16-bit wrapping count of
//                completed transfers (o_w_xfer_count).
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_bus_sequencer
    import reg_bus_sequencer_pkg::*;
#(
    parameter int P_NUM_REGS  = 4,
    parameter int P_IDX_WIDTH = 2
) (
    input  logic                i_w_clk,
    input  logic                i_w_reset,
    reg_bus_sequencer_if.slave  bus
);

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    function automatic logic [P_NUM_REGS-1:0] f_onehot(
        input logic [P_IDX_WIDTH-1:0] idx
    );
        f_onehot = {{(P_NUM_REGS-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Only non-power-of-two banks can see an out-of-range index.
    function automatic logic f_idx_legal(input logic [P_IDX_WIDTH-1:0] idx);
        f_idx_legal = (32'(idx) < 32'(P_NUM_REGS));
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic                   r_ptr;
    logic [P_IDX_WIDTH-1:0] r_src;
    logic [P_IDX_WIDTH-1:0] r_dst;
    logic                   r_id;

    logic [P_NUM_REGS-1:0]  r_oe;
    logic [P_NUM_REGS-1:0]  r_we;
    logic                   r_done;
    logic                   r_done_id;
    logic                   r_err;

    logic [P_NUM_REGS-1:0]  w_oe_nxt;
    logic [P_NUM_REGS-1:0]  w_we_nxt;
    logic                   w_done_nxt;
    logic                   w_done_id_nxt;
    logic                   w_err_nxt;

    // ------------------------------------------------------------------------
    // Arbitration and acceptance
    // ------------------------------------------------------------------------
    logic [1:0]             w_grant;
    logic                   w_gnt_id;
    logic                   w_in_idle;
    logic                   w_accept;
    logic [P_IDX_WIDTH-1:0] w_acc_src;
    logic [P_IDX_WIDTH-1:0] w_acc_dst;
    logic                   w_acc_legal;

    rr_arbiter2 u_arb (
        .i_valid (bus.i_w_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant)
    );

    assign w_in_idle = (r_state == c_st_idle);
    assign w_gnt_id  = w_grant[1];
    // A grant only exists for a valid requester, so grant-in-IDLE is exactly
    // valid && ready for the winner.
    assign w_accept  = w_in_idle && (w_grant != 2'b00);

    assign w_acc_src = w_gnt_id ? bus.i_w_src[2*P_IDX_WIDTH-1:P_IDX_WIDTH]
                                : bus.i_w_src[P_IDX_WIDTH-1:0];
    assign w_acc_dst = w_gnt_id ? bus.i_w_dst[2*P_IDX_WIDTH-1:P_IDX_WIDTH]
                                : bus.i_w_dst[P_IDX_WIDTH-1:0];
    assign w_acc_legal = f_idx_legal(w_acc_src) && f_idx_legal(w_acc_dst);

    assign bus.o_w_ready = w_in_idle ? w_grant : 2'b00;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_w_clk or posedge i_w_reset) begin
        if (i_w_reset) begin
            r_state   <= c_st_idle;
            r_ptr     <= 1'b0;
            r_src     <= '0;
            r_dst     <= '0;
            r_id      <= 1'b0;
            r_oe      <= '0;
            r_we      <= '0;
            r_done    <= 1'b0;
            r_done_id <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_oe      <= w_oe_nxt;
            r_we      <= w_we_nxt;
            r_done    <= w_done_nxt;
            r_done_id <= w_done_id_nxt;
            r_err     <= w_err_nxt;
            if (w_accept) begin
                // Priority passes to the requester that did not just win.
                r_ptr <= ~w_gnt_id;
                r_src <= w_acc_src;
                r_dst <= w_acc_dst;
                r_id  <= w_gnt_id;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                // Rejected commands are consumed without leaving IDLE.
                if (w_accept && w_acc_legal) begin
                    w_state_nxt = c_st_drive;
                end
            end
            c_st_drive: w_state_nxt = c_st_write;
            c_st_write: w_state_nxt = c_st_done;
            c_st_done:  w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic: values the registered outputs take on the next edge, so
    // the bank sees enables aligned with the state being entered.
    // ------------------------------------------------------------------------
    always_comb begin
        w_oe_nxt      = '0;
        w_we_nxt      = '0;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        w_done_id_nxt = r_done_id;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    if (w_acc_legal) begin
                        w_oe_nxt = f_onehot(w_acc_src);
                    end else begin
                        w_err_nxt     = 1'b1;
                        w_done_id_nxt = w_gnt_id;
                    end
                end
            end
            c_st_drive: begin
                w_oe_nxt = f_onehot(r_src);
                // A self-copy needs no write strobe; the register keeps its value.
                if (r_src != r_dst) begin
                    w_we_nxt = f_onehot(r_dst);
                end
            end
            c_st_write: begin
                w_done_nxt    = 1'b1;
                w_done_id_nxt = r_id;
            end
            default: begin
                w_done_id_nxt = r_done_id;
            end
        endcase
    end

    assign bus.o_w_oe      = r_oe;
    assign bus.o_w_we      = r_we;
    assign bus.o_w_done    = r_done;
    assign bus.o_w_done_id = r_done_id;
    assign bus.o_w_err     = r_err;

    // ------------------------------------------------------------------------
    // Optional completed-transfer counter; advances together with the done
    // pulse and wraps naturally at its width.
    // ------------------------------------------------------------------------
`ifdef REG_BUS_SEQ_XFER_COUNT_EN
    logic [c_xfer_cnt_w-1:0] r_xfer_count;

    always_ff @(posedge i_w_clk or posedge i_w_reset) begin
        if (i_w_reset) begin
            r_xfer_count <= '0;
        end else if (w_done_nxt) begin
            r_xfer_count <= r_xfer_count + 1'b1;
        end
    end

    assign bus.o_w_xfer_count = r_xfer_count;
`endif

endmodule : reg_bus_sequencer
`default_nettype wire

// File: tb/tb_reg_bus_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_bus_sequencer
//  Description : Self-checking bench. u_dut4 (4 registers) drives a small
//                register-bank model; a scoreboard queue holds expected
//                transfers pushed by the stimulus and popped on each done
//                pulse. u_dut3 (3 registers) exercises illegal indices.
//                With REG_BUS_SEQ_XFER_COUNT_EN the transfer counters are
//                checked as well.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_bus_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reg_bus_sequencer_if #(.P_NUM_REGS(4), .P_IDX_WIDTH(2)) bus4 ();
    reg_bus_sequencer_if #(.P_NUM_REGS(3), .P_IDX_WIDTH(2)) bus3 ();

    reg_bus_sequencer #(.P_NUM_REGS(4), .P_IDX_WIDTH(2)) u_dut4 (
        .i_w_clk   (clk),
        .i_w_reset (rst),
        .bus       (bus4)
    );

    reg_bus_sequencer #(.P_NUM_REGS(3), .P_IDX_WIDTH(2)) u_dut3 (
        .i_w_clk   (clk),
        .i_w_reset (rst),
        .bus       (bus3)
    );

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Register bank model for u_dut4
    // ------------------------------------------------------------------------
    logic [7:0] regs [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
    logic [7:0] data_bus;

    always_comb begin
        data_bus = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (bus4.o_w_oe[i]) data_bus = regs[i];
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                if (bus4.o_w_we[i]) regs[i] <= data_bus;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Scoreboard for u_dut4
    // ------------------------------------------------------------------------
    typedef struct {
        logic       id;
        logic [1:0] src;
        logic [1:0] dst;
        int         acc;   // cycle number seen on the negedge before accept
    } xfer_t;

    xfer_t      exp_q[$];
    logic [3:0] oe_h1 = '0, oe_h2 = '0, we_h1 = '0, we_h2 = '0;

    always @(negedge clk) begin : mon
        xfer_t x;
        if (!rst && bus4.o_w_done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(bus4.o_w_done), 32'd0);
            end else begin
                x = exp_q.pop_front();
                check("done_id",  32'(bus4.o_w_done_id), 32'(x.id));
                check("latency",  32'(cyc - x.acc), 32'd3);
                check("drive_oe", 32'(oe_h2), 32'(4'b0001 << x.src));
                check("drive_we", 32'(we_h2), 32'd0);
                check("write_oe", 32'(oe_h1), 32'(4'b0001 << x.src));
                check("write_we", 32'(we_h1),
                      (x.src == x.dst) ? 32'd0 : 32'(4'b0001 << x.dst));
                check("done_oe_we", 32'({bus4.o_w_oe, bus4.o_w_we}), 32'd0);
            end
        end
        oe_h2 <= oe_h1;
        oe_h1 <= bus4.o_w_oe;
        we_h2 <= we_h1;
        we_h1 <= bus4.o_w_we;
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers for u_dut4
    // ------------------------------------------------------------------------
    task automatic xfer(input logic id, input logic [1:0] src, input logic [1:0] dst);
        bit got;
        @(negedge clk);
        if (id) begin
            bus4.i_w_src[3:2] = src;
            bus4.i_w_dst[3:2] = dst;
        end else begin
            bus4.i_w_src[1:0] = src;
            bus4.i_w_dst[1:0] = dst;
        end
        bus4.i_w_valid[id] = 1'b1;
        #1;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            if (bus4.o_w_ready[id]) got = 1'b1;
            else begin
                @(negedge clk);
                #1;
            end
        end
        if (!got) check("ready_timeout", 32'd0, 32'd1);
        else exp_q.push_back('{id: id, src: src, dst: dst, acc: cyc});
        @(posedge clk);
        #1;
        bus4.i_w_valid[id] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        int n0;
        bus4.i_w_valid = '0; bus4.i_w_src = '0; bus4.i_w_dst = '0;
        bus3.i_w_valid = '0; bus3.i_w_src = '0; bus3.i_w_dst = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_oe",      32'(bus4.o_w_oe), 32'd0);
        check("rst_we",      32'(bus4.o_w_we), 32'd0);
        check("rst_done",    32'({bus4.o_w_done, bus4.o_w_done_id}), 32'd0);
        check("rst_err",     32'({bus4.o_w_err, bus3.o_w_err}), 32'd0);
        rst = 1'b0;

        // Reset in the middle of DRIVE: outputs drop at once, no done
        @(negedge clk);
        bus4.i_w_src[1:0] = 2'd1;
        bus4.i_w_dst[1:0] = 2'd2;
        bus4.i_w_valid    = 2'b01;
        #1 check("pre_rst_ready", 32'(bus4.o_w_ready), 32'b01);
        @(posedge clk);
        #1 bus4.i_w_valid = 2'b00;
        @(negedge clk);
        check("pre_rst_oe", 32'(bus4.o_w_oe), 32'b0010);
        #2 rst = 1'b1;
        #1 check("mid_rst_oe_we", 32'({bus4.o_w_oe, bus4.o_w_we}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus4.i_w_valid = 2'b01;
        #1 check("post_rst_ready", 32'(bus4.o_w_ready), 32'b01);
        bus4.i_w_valid = 2'b00;
        repeat (5) @(negedge clk);

        // Single transfer r0: reg1 -> reg3
        xfer(1'b0, 2'd1, 2'd3);
        drain();
        check("bank_r3_single", 32'(regs[3]), 32'h11);

        // Self copy r1: reg2 -> reg2
        xfer(1'b1, 2'd2, 2'd2);
        drain();
        check("bank_r2_self", 32'(regs[2]), 32'h12);

        // Contention: both valid continuously, pointer is back on r0
        @(negedge clk);
        n0 = cyc;
        bus4.i_w_src   = {2'd2, 2'd0};
        bus4.i_w_dst   = {2'd3, 2'd1};
        bus4.i_w_valid = 2'b11;
        exp_q.push_back('{id: 1'b0, src: 2'd0, dst: 2'd1, acc: n0});
        exp_q.push_back('{id: 1'b1, src: 2'd2, dst: 2'd3, acc: n0 + 4});
        exp_q.push_back('{id: 1'b0, src: 2'd0, dst: 2'd1, acc: n0 + 8});
        exp_q.push_back('{id: 1'b1, src: 2'd2, dst: 2'd3, acc: n0 + 12});
        repeat (13) @(negedge clk);
        bus4.i_w_valid = 2'b00;
        drain();
        check("bank_r1_cont", 32'(regs[1]), 32'h10);
        check("bank_r3_cont", 32'(regs[3]), 32'h12);

        // Illegal indices on the 3-register instance
        @(negedge clk);
        bus3.i_w_src   = {2'd3, 2'd0};
        bus3.i_w_dst   = {2'd0, 2'd3};
        bus3.i_w_valid = 2'b01;
        #1 check("ill0_ready", 32'(bus3.o_w_ready), 32'b01);
        @(negedge clk);
        check("ill0_err",     32'(bus3.o_w_err), 32'd1);
        check("ill0_id",      32'(bus3.o_w_done_id), 32'd0);
        check("ill0_oe_we",   32'({bus3.o_w_oe, bus3.o_w_we, bus3.o_w_done}), 32'd0);
        check("ill0_idle",    32'(bus3.o_w_ready), 32'b01);
        bus3.i_w_valid = 2'b00;
        @(negedge clk);
        check("ill0_err_end", 32'(bus3.o_w_err), 32'd0);
        bus3.i_w_valid = 2'b10;
        #1 check("ill1_ready", 32'(bus3.o_w_ready), 32'b10);
        @(negedge clk);
        check("ill1_err",     32'(bus3.o_w_err), 32'd1);
        check("ill1_id",      32'(bus3.o_w_done_id), 32'd1);
        bus3.i_w_valid = 2'b00;
        @(negedge clk);
        check("ill1_quiet",   32'({bus3.o_w_err, bus3.o_w_done, bus3.o_w_oe, bus3.o_w_we}), 32'd0);

        // Five legal transfers on the 3-register instance
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus3.i_w_src   = {2'd0, 2'd0};
            bus3.i_w_dst   = {2'd0, 2'd1};
            bus3.i_w_valid = 2'b01;
            @(negedge clk);
            bus3.i_w_valid = 2'b00;
            check("d3_drive_oe", 32'(bus3.o_w_oe), 32'b001);
            @(negedge clk);
            check("d3_write_we", 32'(bus3.o_w_we), 32'b010);
            @(negedge clk);
            check("d3_done", 32'({bus3.o_w_done, bus3.o_w_done_id}), 32'b10);
            @(negedge clk);
        end

`ifdef REG_BUS_SEQ_XFER_COUNT_EN
        check("xfer_count4", 32'(bus4.o_w_xfer_count), 32'd6);
        check("xfer_count3", 32'(bus3.o_w_xfer_count), 32'd5);
`endif

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_reg_bus_sequencer
`default_nettype wire
